// File: rtl/ip_rx_ctrl_if.sv
// Byte-stream bundle between the MAC, the IPv4 header decoder and the UDP stage.
// slave is the receive sequencer's view; master is the view of the surrounding logic.
interface ip_rx_ctrl_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_last;
   logic        dec_valid;
   logic [7:0]  dec_din;
   logic        dec_done;
   logic        dec_err;
   logic [31:0] dec_sa;
   logic [31:0] dec_da;
   logic        pl_valid;
   logic [7:0]  pl_data;
   logic        pl_last;
   logic [31:0] pl_sa;
   logic        frame_ok;
   logic [15:0] drop_cnt;

   modport slave (
      input  rx_valid, rx_data, rx_last,
      input  dec_done, dec_err, dec_sa, dec_da,
      output dec_valid, dec_din,
      output pl_valid, pl_data, pl_last, pl_sa, frame_ok, drop_cnt
   );

   modport master (
      output rx_valid, rx_data, rx_last,
      output dec_done, dec_err, dec_sa, dec_da,
      input  dec_valid, dec_din,
      input  pl_valid, pl_data, pl_last, pl_sa, frame_ok, drop_cnt
   );
endinterface

// File: rtl/ip_rx_ctrl.sv
// Receive sequencer: strips the Ethernet header, feeds the IP header to the decoder,
// filters on destination address and forwards payload bytes one cycle later.
module ip_rx_ctrl #(
   parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0164,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter int          HDR_TIMEOUT  = 64
) (
   input logic         clk,
   input logic         rst,
   ip_rx_ctrl_if.slave bus
);

   localparam int TW = $clog2(HDR_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, PAYLOAD, DROP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      byte_cnt, byte_cnt_nxt;
   logic [7:0]      etype_hi, etype_hi_nxt;
   logic [TW-1:0]   tmo_cnt;
   logic [31:0]     pl_sa_q;
   logic [7:0]      pl_data_q;
   logic            pl_valid_q, pl_last_q, frame_ok_q;
   logic            pl_valid_nxt, pl_last_nxt, frame_ok_nxt;
   logic [15:0]     drop_q;
   logic            drop_inc, latch_sa;
   logic            addr_ok, tmo_hit;

   assign addr_ok = (bus.dec_da == LOCAL_IP) || (ACCEPT_BCAST && (bus.dec_da == 32'hFFFF_FFFF));
   assign tmo_hit = (tmo_cnt == TW'(HDR_TIMEOUT - 1));

   assign bus.dec_valid = (state == IP_HDR) && bus.rx_valid;
   assign bus.dec_din   = bus.dec_valid ? bus.rx_data : 8'h00;
   assign bus.pl_valid  = pl_valid_q;
   assign bus.pl_data   = pl_data_q;
   assign bus.pl_last   = pl_last_q;
   assign bus.pl_sa     = pl_sa_q;
   assign bus.frame_ok  = frame_ok_q;
   assign bus.drop_cnt  = drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         etype_hi   <= '0;
         tmo_cnt    <= '0;
         pl_sa_q    <= '0;
         pl_data_q  <= '0;
         pl_valid_q <= 1'b0;
         pl_last_q  <= 1'b0;
         frame_ok_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state      <= state_nxt;
         byte_cnt   <= byte_cnt_nxt;
         etype_hi   <= etype_hi_nxt;
         tmo_cnt    <= (state == IP_HDR) ? tmo_cnt + TW'(1) : '0;
         pl_data_q  <= bus.rx_data;
         pl_valid_q <= pl_valid_nxt;
         pl_last_q  <= pl_last_nxt;
         frame_ok_q <= frame_ok_nxt;
         if (latch_sa)
            pl_sa_q <= bus.dec_sa;
         if (drop_inc && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
      end
   end

   // Runt endings and valid gaps are checked first so a frame never strands the FSM in DROP.
   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      etype_hi_nxt = etype_hi;
      pl_valid_nxt = 1'b0;
      pl_last_nxt  = 1'b0;
      frame_ok_nxt = 1'b0;
      drop_inc     = 1'b0;
      latch_sa     = 1'b0;
      case (state)
         IDLE: begin
            byte_cnt_nxt = '0;
            if (bus.rx_valid) begin
               if (bus.rx_last) begin
                  drop_inc = 1'b1;
               end else begin
                  byte_cnt_nxt = 4'd1;
                  state_nxt    = ETH_HDR;
               end
            end
         end
         ETH_HDR: begin
            if (!bus.rx_valid || bus.rx_last) begin
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end else begin
               byte_cnt_nxt = byte_cnt + 4'd1;
               if (byte_cnt == 4'd12)
                  etype_hi_nxt = bus.rx_data;
               if (byte_cnt == 4'd13) begin
                  byte_cnt_nxt = '0;
                  if ({etype_hi, bus.rx_data} == 16'h0800) begin
                     state_nxt = IP_HDR;
                  end else begin
                     drop_inc  = 1'b1;
                     state_nxt = DROP;
                  end
               end
            end
         end
         IP_HDR: begin
            if (!bus.rx_valid || bus.rx_last) begin
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end else if (bus.dec_err) begin
               drop_inc  = 1'b1;
               state_nxt = DROP;
            end else if (bus.dec_done) begin
               if (addr_ok) begin
                  latch_sa     = 1'b1;
                  pl_valid_nxt = 1'b1;
                  state_nxt    = PAYLOAD;
               end else begin
                  drop_inc  = 1'b1;
                  state_nxt = DROP;
               end
            end else if (tmo_hit) begin
               drop_inc  = 1'b1;
               state_nxt = DROP;
            end
         end
         PAYLOAD: begin
            if (!bus.rx_valid) begin
               pl_last_nxt = 1'b1;
               drop_inc    = 1'b1;
               state_nxt   = IDLE;
            end else begin
               pl_valid_nxt = 1'b1;
               if (bus.rx_last) begin
                  pl_last_nxt  = 1'b1;
                  frame_ok_nxt = 1'b1;
                  state_nxt    = IDLE;
               end
            end
         end
         DROP: begin
            if (bus.rx_valid && bus.rx_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
